cam_capture_rgb444: RTL and testbench
=====================================

// Module: cam_capture_rgb444
// PURPOSE
//  Camera capture stage, directly upstream of the dual-port frame buffer. Samples the OV7670
//  byte stream (QQVGA 160x120, RGB444, two bytes per pixel) on the camera pixel clock and
//  packs each pixel into 12 bits. Drives the buffer's write port (addr_in/data_in/regwrite)
//  with linear addresses 0..IMG_W*IMG_H-1. Address IMG_W*IMG_H is the buffer's black pixel
//  and is never written.
// PARAMETERS
//  AW     15   write address width; must satisfy 2**AW > IMG_W*IMG_H
//  DW     12   packed pixel width (RGB444)
//  IMG_W  160  pixels per line kept
//  IMG_H  120  lines per frame kept
// PORTS
//  clk       in   1   camera PCLK; the block's only clock; all logic on posedge
//  reset     in   1   synchronous, active-high
//  cap_en    in   1   1 = capture continuously; sampled only at frame start
//  vsync     in   1   camera VSYNC, high = vertical blank
//  href      in   1   camera HREF, high = valid bytes on px_data
//  px_data   in   8   camera data byte
//  addr      out  AW  buffer write address (to addr_in)
//  data_out  out  DW  packed pixel {R[3:0],G[3:0],B[3:0]} (to data_in)
//  regwrite  out  1   one-cycle write strobe (to regwrite)
//  frame_done out 1   one-cycle pulse: complete frame written
//  frame_err  out 1   one-cycle pulse: frame aborted or short
// BEHAVIOUR
//  Reset: addr=0, data_out=0, regwrite=0, frame_done=0, frame_err=0; state=WAIT_VS;
//   byte phase=HI; line/col counters=0. Reset mid-frame discards the frame; no write occurs.
//  Inputs vsync/href/px_data are registered once (1-cycle input stage); all decisions use
//   the registered copies.
//  FSM:
//   WAIT_VS  : wait for vsync=1 -> WAIT_FS.
//   WAIT_FS  : on vsync 1->0: if cap_en -> ACTIVE (addr=0, line=0, col=0, phase=HI);
//              else -> WAIT_VS.
//   ACTIVE   : byte stream per line while href=1:
//              phase HI: latch px_data[3:0] as R; phase->LO.
//              phase LO: if col<IMG_W and line<IMG_H: next cycle data_out={R,px_data},
//              regwrite=1, addr=current write address; address then increments by 1. col++.
//              phase->HI.
//              href 1->0: line++ if col>0; col=0; phase=HI (odd trailing byte dropped).
//              vsync 0->1: if line>=IMG_H -> pulse frame_done; else pulse frame_err;
//              -> WAIT_FS (vsync already high).
//  Write latency: regwrite asserted exactly 2 cycles after the raw LO byte is on px_data
//   (input reg + output reg). addr/data_out valid in the same cycle as regwrite.
//  regwrite never asserted outside ACTIVE; at most one per two PCLK cycles.
//  Overflow: pixels with col>=IMG_W or lines with line>=IMG_H are dropped; addr saturates
//   at IMG_W*IMG_H-1 and never reaches IMG_W*IMG_H.
//  Address arithmetic: addr is a running counter (no multiplier), width AW, cleared at frame
//   start; a line shorter than IMG_W leaves the next line starting at the running address.
//  frame_done and frame_err mutually exclusive, one cycle each, registered.
//  cap_en deasserted mid-frame: current frame completes; no new frame starts.
// STRUCTURE
//  Shared package/header cam_pkg: IMG_W, IMG_H, IMG_SIZE=IMG_W*IMG_H, BLACK_ADDR=IMG_SIZE,
//   FSM state encoding (WAIT_VS, WAIT_FS, ACTIVE), pixel-packing macro.
//  One sub-module: cam_sync_edge (register + rise/fall pulse for vsync and href).
//  Remainder flat: FSM, byte-phase flop, col/line counters, address counter, output regs.
// TESTING
//  1 Full frame, cap_en=1, 120 lines x 160 px, bytes 0x0A,0xBC -> 19200 writes,
//    data_out=12'hABC, addr 0..19199 in order, one frame_done, no frame_err.
//  2 Line with 170 px -> only 160 writes for that line; next line starts at addr+160.
//  3 vsync rises after 60 lines -> frame_err pulse, 9600 writes, next frame restarts at 0.
//  4 Line of 321 bytes (odd) -> 160 writes, trailing byte dropped, phase HI on next line.
//  5 Reset asserted at line 30 -> outputs 0 next cycle, no writes until next vsync fall.
//  6 cap_en=0 at vsync fall -> zero writes that frame; addr never equals 19200 in any test.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared constants, FSM encoding and pixel packing for the OV7670 RGB444 capture path.
package cam_pkg;

  localparam int IMG_W      = 160;
  localparam int IMG_H      = 120;
  localparam int IMG_SIZE   = IMG_W * IMG_H;
  // The frame buffer reserves this address for its black pixel, so capture never writes it.
  localparam int BLACK_ADDR = IMG_SIZE;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    WAIT_FS = 2'd1,
    ACTIVE  = 2'd2
  } cap_state_t;

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } byte_phase_t;

  function automatic logic [11:0] pack_rgb444(input logic [3:0] r,
                                              input logic [3:0] g,
                                              input logic [3:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// Registers one camera sync line and derives single-cycle rise/fall pulses from the registered copy.
module cam_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      level <= din;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;
  assign fall = ~level & prev;

endmodule

// File: rtl/cam_capture_rgb444.sv
// OV7670 QQVGA RGB444 capture: packs two camera bytes per pixel and drives the
// frame buffer write port with a saturating running address.
module cam_capture_rgb444 #(
  parameter int AW    = 15,
  parameter int DW    = 12,
  parameter int IMG_W = cam_pkg::IMG_W,
  parameter int IMG_H = cam_pkg::IMG_H
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cap_en,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_out,
  output logic          regwrite,
  output logic          frame_done,
  output logic          frame_err
);

  import cam_pkg::*;

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CW        = $clog2(IMG_W + 1);
  localparam int LW        = $clog2(IMG_H + 1);

  localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);
  localparam logic [LW-1:0] LINE_LIM  = LW'(IMG_H);
  localparam logic [AW-1:0] ADDR_LAST = AW'(FRAME_PIX - 1);

  logic vs_lvl, vs_rise, vs_fall;
  logic hr_lvl, hr_rise, hr_fall;

  cam_sync_edge u_vsync_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vsync),
    .level (vs_lvl),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_sync_edge u_href_edge (
    .clk   (clk),
    .reset (reset),
    .din   (href),
    .level (hr_lvl),
    .rise  (hr_rise),
    .fall  (hr_fall)
  );

  cap_state_t    state;
  byte_phase_t   phase;
  logic [7:0]    px_q;
  logic [3:0]    red_q;
  logic [CW-1:0] col;
  logic [LW-1:0] line;
  logic [AW-1:0] wr_addr;

  // The first byte after an href rise is always treated as the red byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_VS;
      phase      <= PH_HI;
      px_q       <= '0;
      red_q      <= '0;
      col        <= '0;
      line       <= '0;
      wr_addr    <= '0;
      addr       <= '0;
      data_out   <= '0;
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      px_q       <= px_data;
      regwrite   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;

      unique case (state)
        WAIT_VS: begin
          if (vs_lvl) state <= WAIT_FS;
        end

        WAIT_FS: begin
          if (vs_fall) begin
            if (cap_en) begin
              state   <= ACTIVE;
              wr_addr <= '0;
              addr    <= '0;
              line    <= '0;
              col     <= '0;
              phase   <= PH_HI;
            end else begin
              state <= WAIT_VS;
            end
          end
        end

        ACTIVE: begin
          if (vs_rise) begin
            if (line >= LINE_LIM) frame_done <= 1'b1;
            else                  frame_err  <= 1'b1;
            state <= WAIT_FS;
          end else if (hr_fall) begin
            if (col != '0 && line != LINE_LIM) line <= line + LW'(1);
            col   <= '0;
            phase <= PH_HI;
          end else if (hr_lvl) begin
            if (phase == PH_HI || hr_rise) begin
              red_q <= px_q[3:0];
              phase <= PH_LO;
            end else begin
              if (col < COL_LIM && line < LINE_LIM) begin
                regwrite <= 1'b1;
                addr     <= wr_addr;
                data_out <= DW'(pack_rgb444(red_q, px_q[7:4], px_q[3:0]));
                if (wr_addr != ADDR_LAST) wr_addr <= wr_addr + AW'(1);
              end
              if (col != COL_LIM) col <= col + CW'(1);
              phase <= PH_HI;
            end
          end
        end

        default: state <= WAIT_VS;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture_rgb444.sv
// Self-checking bench for cam_capture_rgb444: per-frame byte streams with a queue-based pixel model.
module tb_cam_capture_rgb444;

  import cam_pkg::*;

  localparam int AW = 15;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          cap_en;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          regwrite;
  logic          frame_done;
  logic          frame_err;

  cam_capture_rgb444 #(
    .AW    (AW),
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cap_en     (cap_en),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr       (addr),
    .data_out   (data_out),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned addr;
    logic [11:0] data;
    int unsigned cyc;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  bit          prev_rw = 1'b0;

  bit m_cap = 1'b0;
  int m_lines = 0;
  int m_addr = 0;
  int exp_wr = 0;
  int d0 = 0;
  int e0 = 0;
  int w0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Every strobe must match the oldest predicted pixel in address, data and arrival cycle.
  always @(negedge clk) begin
    if (regwrite === 1'b1) begin
      wr_cnt++;
      checkOutput("no_back_to_back", 32'(prev_rw), 32'd0);
      checkOutput("addr_not_black", 32'(addr != AW'(BLACK_ADDR)), 32'd1);
      checkOutput("write_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(addr), mon_e.addr);
        checkOutput("wr_data", 32'(data_out), 32'(mon_e.data));
        checkOutput("wr_latency", cyc, mon_e.cyc);
      end
    end
    prev_rw = (regwrite === 1'b1);
    if (frame_done === 1'b1) done_cnt++;
    if (frame_err === 1'b1) err_cnt++;
    if (frame_done === 1'b1 || frame_err === 1'b1)
      checkOutput("done_err_excl", 32'(frame_done & frame_err), 32'd0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      href    = 1'b0;
      px_data = 8'($urandom);
    end
  endtask

  // Drives one href-high line and predicts the writes it should cause.
  task automatic applyStimulus(input int nbytes, input bit fixed_pat);
    logic [7:0] b;
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < nbytes; i++) begin
      if (fixed_pat) b = (i % 2 == 0) ? 8'h0A : 8'hBC;
      else           b = 8'($urandom);
      @(posedge clk); #1;
      href    = 1'b1;
      px_data = b;
      if (i % 2 == 0) begin
        r = b[3:0];
      end else if (m_cap && m_lines < IMG_H && (i / 2) < IMG_W) begin
        exp_q.push_back('{addr: 32'(m_addr), data: {r, b}, cyc: cyc + 2});
        m_addr++;
        exp_wr++;
      end
    end
    if (m_cap && nbytes >= 2) m_lines++;
  endtask

  task automatic frame_start(input bit cap);
    @(posedge clk); #1;
    href  = 1'b0;
    vsync = 1'b1;
    idle(4);
    @(posedge clk); #1;
    cap_en  = cap;
    vsync   = 1'b0;
    m_cap   = cap;
    m_lines = 0;
    m_addr  = 0;
    exp_wr  = 0;
    d0      = done_cnt;
    e0      = err_cnt;
    w0      = wr_cnt;
    idle(6);
  endtask

  task automatic frame_end(input string tag);
    bit ed;
    bit ee;
    ed = m_cap && (m_lines >= IMG_H);
    ee = m_cap && !ed;
    @(posedge clk); #1;
    href  = 1'b0;
    vsync = 1'b1;
    m_cap = 1'b0;
    idle(6);
    checkOutput({tag, "_done"}, 32'(done_cnt - d0), 32'(ed));
    checkOutput({tag, "_err"}, 32'(err_cnt - e0), 32'(ee));
    checkOutput({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
    checkOutput({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    reset   = 1'b1;
    cap_en  = 1'b0;
    vsync   = 1'b0;
    href    = 1'b0;
    px_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_addr", 32'(addr), 32'd0);
    checkOutput("rst_data", 32'(data_out), 32'd0);
    checkOutput("rst_regwrite", 32'(regwrite), 32'd0);
    checkOutput("rst_done", 32'(frame_done), 32'd0);
    checkOutput("rst_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] frame A: full frame, fixed 0x0A/0xBC, one 170 px line and one 321 byte line");
    frame_start(1'b1);
    for (int l = 0; l < IMG_H; l++) begin
      if (l == 2)      applyStimulus(340, 1'b1);
      else if (l == 3) applyStimulus(321, 1'b1);
      else             applyStimulus(320, 1'b1);
      idle(4);
    end
    frame_end("A");
    checkOutput("A_total", 32'(wr_cnt - w0), 32'(IMG_SIZE));

    $display("[TB] frame B: vsync after 60 random lines");
    frame_start(1'b1);
    for (int l = 0; l < 60; l++) begin
      applyStimulus(320, 1'b0);
      idle(4);
    end
    frame_end("B");
    checkOutput("B_total", 32'(wr_cnt - w0), 32'(IMG_SIZE / 2));

    $display("[TB] frame C: reset in the middle of line 30");
    frame_start(1'b1);
    for (int l = 0; l < 30; l++) begin
      applyStimulus(320, 1'b0);
      idle(4);
    end
    applyStimulus(100, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    href  = 1'b0;
    m_cap = 1'b0;
    while (exp_q.size() != 0 && exp_q[$].cyc > cyc) begin
      void'(exp_q.pop_back());
      exp_wr--;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("C_rst_addr", 32'(addr), 32'd0);
    checkOutput("C_rst_data", 32'(data_out), 32'd0);
    checkOutput("C_rst_regwrite", 32'(regwrite), 32'd0);
    checkOutput("C_rst_done", 32'(frame_done), 32'd0);
    checkOutput("C_rst_err", 32'(frame_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int l = 0; l < 3; l++) begin
      applyStimulus(320, 1'b0);
      idle(4);
    end
    frame_end("C");

    $display("[TB] frame D: cap_en low at frame start");
    frame_start(1'b0);
    for (int l = 0; l < 4; l++) begin
      applyStimulus(320, 1'b0);
      idle(4);
    end
    frame_end("D");

    $display("[TB] frame E: random line lengths, cap_en dropped mid-frame");
    frame_start(1'b1);
    applyStimulus(int'($urandom_range(0, 341)), 1'b0);
    idle(4);
    cap_en = 1'b0;
    for (int l = 0; l < 5; l++) begin
      applyStimulus(int'($urandom_range(0, 341)), 1'b0);
      idle(4);
    end
    frame_end("E");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
